// File: rtl/uart_pkg.sv
// Shared UART receiver types: frame state encoding, parity mode codes and baud divisor helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit, rounded to nearest.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous line.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
// Ports: clk, rst (async active-high), d (async input), q (synchronised output, resets to 1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Reset to 1 so an idle line never looks like a start bit coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection and framing/parity/overrun detection.
// Latency: data_valid rises 1 cycle after the final stop-bit sample (plus 2 cycles of input sync).
// Backpressure: one-word output slot; a frame completing while the slot is held is dropped with an overrun_err pulse.
// Ports: clk, rst (async active-high), rx_pin (idle high); data_out/data_valid/data_ready handshake,
//        frame_err/parity_err qualified by data_valid, overrun_err 1-cycle pulse, busy = not idle.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling at S-2D, S-D, S (D = CLKS_PER_BIT/16).
module uart_rx_param #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int CLKS  = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int CNT_W = (CLKS > 1) ? $clog2(CLKS) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam int DLT   = CLKS / 16;
    localparam logic [CNT_W-1:0] S_FULL    = CNT_W'(CLKS - 1);
    localparam logic [CNT_W-1:0] S_HALF    = CNT_W'(CLKS / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_pin),
        .q   (rx_s)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    logic [CNT_W-1:0]     s_nom;
    logic                 at_s;
    logic                 bit_s;
    logic                 done;
    logic                 par_exp;

    // Start bit is judged at mid-bit; every later bit one full period after the previous decision.
    assign s_nom = (state_q == START) ? S_HALF : S_FULL;
    assign at_s  = (cnt_q == s_nom);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    // Two early votes are captured inside the current bit; the third is the live value at S.
    always_comb begin
        vote_d = vote_q;
        if (cnt_q == s_nom - CNT_W'(2 * DLT)) vote_d[0] = rx_s;
        if (cnt_q == s_nom - CNT_W'(DLT))     vote_d[1] = rx_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vote_q <= 2'b11;
        else     vote_q <= vote_d;
    end

    // With very short bit periods the three points collapse onto S.
    assign bit_s = (DLT == 0) ? rx_s
                 : ((vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s));
`else
    assign bit_s = rx_s;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        ovr_d      = 1'b0;
        done       = 1'b0;
        par_exp    = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (at_s) begin
                    cnt_d = '0;
                    if (!bit_s) begin
                        state_d    = DATA;
                        idx_d      = '0;
                        shift_d    = '0;
                        par_flag_d = 1'b0;
                        frm_flag_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (at_s) begin
                    cnt_d   = '0;
                    // LSB-first shift: after DATA_BITS samples bit 0 sits at index 0.
                    shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            uart_pkg::PARITY: begin
                if (at_s) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = STOP;
                    if (bit_s != par_exp) par_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (at_s) begin
                    cnt_d = '0;
                    if (!bit_s) frm_flag_d = 1'b1;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Output slot: a completing frame may replace a word that is being accepted this cycle.
        if (done) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                ferr_d  = frm_flag_d;
                perr_d  = par_flag_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_err   = ferr_q;
    assign parity_err  = perr_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two receivers (8N1 and 7E2) at 16 clocks per bit.
// Latency: n/a.
// Backpressure: data_ready driven per test; held low to force an overrun.
module tb_uart_rx_param;

    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int CPB    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       val_a, val_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int vcnt_a = 0;
    int ovcnt_a = 0;
    int busy_seen_a = 0;
    int vrise_cyc = 0;
    logic val_a_prev = 1'b0;
    logic [10:0] got_a[$];
    logic [10:0] got_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx_pin(rx_a), .data_out(dout_a), .data_valid(val_a),
        .data_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a), .busy(busy_a)
    );

    uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx_pin(rx_b), .data_out(dout_b), .data_valid(val_b),
        .data_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b), .busy(busy_b)
    );

    // Observe on the falling edge: a word is consumed when valid and ready are both high.
    always @(negedge clk) begin
        if (val_a && rdy_a) got_a.push_back({pe_a, fe_a, 1'b0, dout_a});
        if (val_b && rdy_b) got_b.push_back({pe_b, fe_b, 2'b00, dout_b});
        if (val_a) vcnt_a++;
        if (val_a && !val_a_prev) vrise_cyc = cyc;
        val_a_prev = val_a;
        if (ov_a) ovcnt_a++;
        if (busy_a) busy_seen_a++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic pe, input logic fe, input logic [8:0] d);
        return {pe, fe, d};
    endfunction

    // Drive one frame bit-by-bit on the chosen line; optional 1-cycle inversion at mid-bit of each data bit.
    task automatic send(input int which, input logic [8:0] dat, input int nbits, input bit has_par,
                        input logic pbit, input int nstop, input logic [1:0] stopv,
                        input bit glitch, input int gap);
        logic [15:0] bits;
        int n;
        logic v;
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nbits; i++) begin bits[n] = dat[i]; n++; end
        if (has_par) begin bits[n] = pbit; n++; end
        for (int s = 0; s < nstop; s++) begin bits[n] = stopv[s]; n++; end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk); #1;
                if (b == 0 && c == 0) start_cyc = cyc;
                v = bits[b];
                if (glitch && b >= 1 && b <= nbits && c == CPB / 2) v = ~v;
                if (which == 0) rx_a = v; else rx_b = v;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
        end
    endtask

    task automatic check_rx(input int which, input string tag, input logic [10:0] exp);
        int k = 0;
        int sz;
        logic [10:0] got;
        sz = (which == 0) ? got_a.size() : got_b.size();
        while (sz == 0 && k < 4000) begin
            @(posedge clk); #1;
            k++;
            sz = (which == 0) ? got_a.size() : got_b.size();
        end
        chk({tag, "_rcvd"}, (sz > 0), 1);
        if (sz > 0) begin
            got = (which == 0) ? got_a.pop_front() : got_b.pop_front();
            chk(tag, got, exp);
        end
    endtask

    initial begin
        logic [8:0] d;
        logic [1:0] sv;
        logic pbad, pb;
        int w;
        logic [7:0] maj_exp;

        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_a", {dout_a, val_a, fe_a, pe_a, ov_a, busy_a}, 0);
        chk("rst_outs_b", {dout_b, val_b, fe_b, pe_b, ov_b, busy_b}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_after_rst", {val_a, busy_a, val_b, busy_b}, 0);

        // 8N1 basic frame, latency and single-cycle valid pulse.
        @(posedge clk); #1 vcnt_a = 0;
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 0, 2 * CPB);
        check_rx(0, "a5_frame", mk(0, 0, 9'h0A5));
        chk("a5_latency", vrise_cyc - start_cyc, 9 * CPB + CPB / 2 + 3);
        chk("a5_vld_pulse", vcnt_a, 1);
        chk("a5_busy_after", busy_a, 0);

        // 7E2: good parity, bad parity, bad second stop bit, then clean frame.
        d = 9'h041;
        send(1, d, 7, 1, ^d[6:0], 2, 2'b11, 0, 2 * CPB);
        check_rx(1, "par_good", mk(0, 0, 9'h041));
        send(1, d, 7, 1, ~(^d[6:0]), 2, 2'b11, 0, 2 * CPB);
        check_rx(1, "par_bad", mk(1, 0, 9'h041));
        d = 9'h02B;
        send(1, d, 7, 1, ^d[6:0], 2, 2'b01, 0, 2 * CPB);
        check_rx(1, "stop2_bad", mk(0, 1, 9'h02B));
        d = 9'h03C;
        send(1, d, 7, 1, ^d[6:0], 2, 2'b11, 0, 2 * CPB);
        check_rx(1, "after_ferr", mk(0, 0, 9'h03C));

        // Overrun: slot held, second frame dropped.
        @(posedge clk); #1 rdy_a = 1'b0; ovcnt_a = 0;
        send(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, 0, 2 * CPB);
        send(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, 0, 2 * CPB);
        @(negedge clk);
        chk("ovr_hold_data", dout_a, 8'h11);
        chk("ovr_hold_vld", val_a, 1);
        chk("ovr_pulses", ovcnt_a, 1);
        chk("ovr_nothing_taken", got_a.size(), 0);
        @(posedge clk); #1 rdy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_vld_cleared", val_a, 0);
        check_rx(0, "ovr_word", mk(0, 0, 9'h011));

        // False start: short low pulse on idle line.
        @(posedge clk); #1 busy_seen_a = 0; vcnt_a = 0; rx_a = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        chk("fs_busy_seen", (busy_seen_a > 0), 1);
        chk("fs_idle", busy_a, 0);
        chk("fs_no_vld", vcnt_a, 0);

        // Reset in the middle of the data bits.
        got_a.delete();
        @(posedge clk); #1 rx_a = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy_a, 1);
        @(posedge clk); #1 rst = 1'b1; rx_a = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {dout_a, val_a, fe_a, pe_a, ov_a, busy_a}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1 vcnt_a = 0;
        send(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11, 0, 2 * CPB);
        check_rx(0, "post_rst_frame", mk(0, 0, 9'h05A));
        chk("post_rst_one_word", vcnt_a, 1);

        // Mid-bit glitch on every data bit.
`ifdef UART_RX_MAJORITY_EN
        maj_exp = 8'hC3;
`else
        maj_exp = 8'h3C;
`endif
        send(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11, 1, 2 * CPB);
        check_rx(0, "glitch_frame", mk(0, 0, {1'b0, maj_exp}));

        // Break: line held low for a whole frame.
        got_a.delete();
        @(posedge clk); #1 rx_a = 1'b0;
        repeat (10 * CPB) @(posedge clk);
        #1 rx_a = 1'b1;
        check_rx(0, "break_frame", mk(0, 1, 9'h000));
        repeat (3 * 12 * CPB) @(posedge clk);
        @(negedge clk);
        chk("break_idle", busy_a, 0);
        got_a.delete();
        send(0, 9'h096, 8, 0, 1'b0, 1, 2'b11, 0, 2 * CPB);
        check_rx(0, "break_recover", mk(0, 0, 9'h096));

        // Random frames on both receivers against the frame-level model.
        for (int i = 0; i < 24; i++) begin
            w = $urandom_range(0, 1);
            if (w == 0) begin
                d = {1'b0, 8'($urandom_range(0, 255))};
                sv = {1'b1, ($urandom_range(0, 7) != 0)};
                send(0, d, 8, 0, 1'b0, 1, sv, 0, $urandom_range(2 * CPB, 3 * CPB));
                check_rx(0, "rand_a", mk(0, ~sv[0], d));
            end else begin
                d = {2'b00, 7'($urandom_range(0, 127))};
                pbad = ($urandom_range(0, 3) == 0);
                pb = (^d[6:0]) ^ pbad;
                sv[0] = ($urandom_range(0, 3) != 0);
                sv[1] = ($urandom_range(0, 3) != 0);
                send(1, d, 7, 1, pb, 2, sv, 0, $urandom_range(2 * CPB, 3 * CPB));
                check_rx(1, "rand_b", mk(pbad, ~(sv[0] & sv[1]), d));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver; the next generation of the team's fixed 8N1 9600-baud receiver.
- Configurable clock/baud, data width, parity and stop bits.
- Input synchroniser, false-start rejection, and framing/parity/overrun detection.
- Ready/valid output handshake.
- Sits between the board RX pin and the LED/command logic on Basys-3 class designs.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD, 9600, line rate. CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD/2) / BAUD, rounded; 10417 at defaults.
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame, legal 1..2.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  reset; asynchronous, active-high.
- rx_pin  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  received word.
- data_valid  out  1  word held on data_out.
- data_ready  in  1  consumer accepts the word.
- frame_err  out  1  a stop bit sampled 0; qualified by data_valid.
- parity_err  out  1  parity mismatch, always 0 when PARITY=0; qualified by data_valid.
- overrun_err  out  1  one-cycle pulse: a frame completed and was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: rx_pin synchroniser flops = 1; state = IDLE; counters = 0; data_out = 0; data_valid = frame_err = parity_err = overrun_err = busy = 0.
- Synchroniser: 2-flop on rx_pin; all logic uses the synchronised value rx_s. This adds 2 cycles of input latency.
- Counters: bit-period counter clog2(CLKS_PER_BIT) bits; bit index counter clog2(DATA_BITS+1) bits.
- IDLE: rx_s==0 -> START, counter cleared.
- START: counts to CLKS_PER_BIT/2 - 1 (integer division), then samples rx_s.
  - Sample 0: go to DATA; counter, bit index and shift buffer cleared.
  - Sample 1: false start, go to IDLE; no outputs change.
- DATA: at count CLKS_PER_BIT-1, sample into buffer[bit index], increment index, clear counter.
  - After bit DATA_BITS-1: go to PARITY if PARITY!=0, else STOP.
- PARITY: one bit period, then sample.
  - Expected value: odd mode = ~^buffer; even mode = ^buffer.
  - A mismatch latches the internal parity flag.
- STOP: STOP_BITS periods, each sampled at count CLKS_PER_BIT-1. Any 0 sample latches the internal frame flag.
- After the final stop sample: go to IDLE in the same cycle. The frame is then complete and is presented to the output stage.
- Output stage, evaluated on the completion cycle:
  - Slot empty (data_valid==0), or being emptied this cycle (data_valid & data_ready): load data_out, frame_err and parity_err, and set data_valid=1 on the next edge.
  - Otherwise (data_valid & !data_ready): drop the new frame, keep the held word and flags, and pulse overrun_err for 1 cycle.
- Handshake:
  - data_valid & data_ready with no completion -> data_valid=0 on the next edge.
  - While data_valid=1, data_out and the error flags are stable.
- A frame with frame_err or parity_err is still delivered; the flags accompany it.
- Latency: data_valid rises 1 cycle after the last stop sample.
- rx held low (break): completes as a frame with frame_err=1. The receiver then restarts from IDLE and re-arms on rx_s==0.
- rst asserted mid-frame: immediate return to reset values. A partial frame is never delivered.

Optional Feature:
Macro: UART_RX_MAJORITY_EN
- Defined:
  - Each start/data/parity/stop decision uses a 2-of-3 majority of rx_s.
  - Sample points are S-2D, S-D and S, where S is the nominal sample count and D = CLKS_PER_BIT/16.
  - The decision is taken at S, so the timing is unchanged.
  - A single-cycle glitch at any one sample point does not alter the bit.
- Not defined: single sample at S, as specified above.

Decomposition:
- Package uart_pkg:
  - state enum IDLE/START/DATA/PARITY/STOP;
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - function clks_per_bit(clk_hz, baud) with rounding.
- Sub-module uart_rx_sync: 2-flop synchroniser, reset value 1. It is shared with future receivers.

Test Plan:
- Defaults, send 0xA5 8N1, data_ready=1 -> data_out=0xA5, data_valid pulses 1 cycle, no errors, busy low afterwards.
- PARITY=2, DATA_BITS=7: send 0x41 with correct parity 0 -> parity_err=0. Repeat with parity bit 1 -> parity_err=1 and data_out=0x41.
- STOP_BITS=2, second stop bit driven 0 -> frame_err=1, data delivered. A following good 0x3C frame -> frame_err=0.
- data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun_err pulses once. Assert ready -> valid clears.
- Low glitch of CLKS_PER_BIT/4 on idle line -> state returns to IDLE, no data_valid. Assert rst mid-DATA -> all outputs 0, next frame 0x5A received correctly.
- With UART_RX_MAJORITY_EN: 1-cycle inverted glitch at mid-bit of each data bit of 0xC3 -> data_out=0xC3. Without the macro, the same stimulus produces 0x3C.
